// File: rtl/apb_master_bridge.sv
// APB requester: one SETUP->ACCESS transfer per accepted command, response on a one-cycle strobe.
// Optional ACCESS wait-state timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              prst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              psel,
   output logic              pen,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic              pready,
   input  logic [DATA_W-1:0] prdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   accept;
   logic   done;
   logic   abort;
   logic   timeout_hit;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("apb_master_bridge: TIMEOUT must be >= 1");
   end

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] wait_cnt;

   // Held at zero outside ACCESS so every transfer starts its count fresh.
   always_ff @(posedge pclk or negedge prst) begin
      if (!prst) begin
         wait_cnt <= '0;
      end else if (state != ACCESS) begin
         wait_cnt <= '0;
      end else if (!pready) begin
         wait_cnt <= wait_cnt + CW'(1);
      end
   end

   assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge pclk or negedge prst) begin
      if (!prst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      done      = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               accept    = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            state_nxt = ACCESS;
         end
         ACCESS: begin
            // pready at the final timeout edge still counts as a normal completion.
            if (pready) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else if (timeout_hit) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge prst) begin
      if (!prst) begin
         cmd_ready <= 1'b1;
         psel      <= 1'b0;
         pen       <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         cmd_ready <= (state_nxt == IDLE);
         psel      <= (state_nxt != IDLE);
         pen       <= (state_nxt == ACCESS);
         rsp_valid <= done | abort;
         if (accept) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
         end
         if (done) begin
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= 1'b0;
         end else if (abort) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge; responses are checked against a queue of expected results.
module tb_apb_master_bridge;

   logic       pclk = 1'b0;
   logic       prst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [7:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       psel;
   logic       pen;
   logic       pwrite;
   logic [7:0] paddr;
   logic [7:0] pwdata;
   logic       pready;
   logic [7:0] prdata;

   typedef struct packed {
      logic [7:0] rdata;
      logic       err;
   } rsp_t;

   rsp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   logic prev_rv = 1'b0;

   apb_master_bridge #(
      .ADDR_W (8),
      .DATA_W (8),
      .TIMEOUT(4)
   ) dut (
      .pclk     (pclk),
      .prst     (prst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr (cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .psel     (psel),
      .pen      (pen),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .pready   (pready),
      .prdata   (prdata)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic mid();
      @(negedge pclk);
   endtask

   // Response scoreboard
   always @(negedge pclk) begin
      rsp_t e;
      if (rsp_valid === 1'b1) begin
         chk("rsp_double", {31'd0, prev_rv}, 32'd0);
         chk("rsp_expected", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
         end
      end
      prev_rv = (rsp_valid === 1'b1);
   end

   initial begin
      prst      = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      pready    = 1'b0;
      prdata    = '0;
      #2 prst = 1'b0;
      tick();
      tick();
      mid();
      chk("rst_psel", psel, 0);
      chk("rst_pen", pen, 0);
      chk("rst_pwrite", pwrite, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_pwdata", pwdata, 0);
      chk("rst_rv", rsp_valid, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_err", rsp_err, 0);
      tick();
      prst = 1'b1;

      // Stray pready/prdata while idle
      for (int i = 0; i < 4; i++) begin
         tick();
         pready = (i % 2 == 1);
         prdata = (i % 2 == 1) ? 8'hFF : 8'h00;
         mid();
         chk("idle_psel", psel, 0);
         chk("idle_rv", rsp_valid, 0);
         chk("idle_ready", cmd_ready, 1);
      end

      // Read with 3 wait states
      tick();
      pready    = 1'b0;
      prdata    = 8'hFF;
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 8'h40;
      cmd_wdata = 8'h99;
      exp_q.push_back('{rdata: 8'h3C, err: 1'b0});
      mid();
      chk("rd_ready_c0", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      mid();
      chk("rd_setup_psel", psel, 1);
      chk("rd_setup_pen", pen, 0);
      chk("rd_setup_paddr", paddr, 8'h40);
      chk("rd_setup_pwrite", pwrite, 0);
      for (int c = 2; c <= 5; c++) begin
         tick();
         if (c == 5) begin
            pready = 1'b1;
            prdata = 8'h3C;
         end
         mid();
         chk("rd_access_pen", pen, 1);
         chk("rd_access_paddr", paddr, 8'h40);
         chk("rd_access_rv", rsp_valid, 0);
      end
      tick();
      pready = 1'b0;
      prdata = 8'h00;
      mid();
      chk("rd_c6_rv", rsp_valid, 1);
      chk("rd_c6_rdata", rsp_rdata, 8'h3C);
      chk("rd_c6_pen", pen, 0);
      chk("rd_c6_psel", psel, 0);
      chk("rd_c6_ready", cmd_ready, 1);

      // Write, zero wait states, pready already high during SETUP
      tick();
      pready    = 1'b1;
      prdata    = 8'hFF;
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 8'h12;
      cmd_wdata = 8'hA5;
      exp_q.push_back('{rdata: 8'h00, err: 1'b0});
      mid();
      chk("wr_ready_c0", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      mid();
      chk("wr_c1_psel", psel, 1);
      chk("wr_c1_pen", pen, 0);
      chk("wr_c1_paddr", paddr, 8'h12);
      chk("wr_c1_pwdata", pwdata, 8'hA5);
      chk("wr_c1_pwrite", pwrite, 1);
      chk("wr_c1_ready", cmd_ready, 0);
      chk("wr_c1_rv", rsp_valid, 0);
      tick();
      mid();
      chk("wr_c2_psel", psel, 1);
      chk("wr_c2_pen", pen, 1);
      chk("wr_c2_rv", rsp_valid, 0);
      tick();
      mid();
      chk("wr_c3_rv", rsp_valid, 1);
      chk("wr_c3_rdata", rsp_rdata, 8'h00);
      chk("wr_c3_err", rsp_err, 0);
      chk("wr_c3_psel", psel, 0);
      chk("wr_c3_ready", cmd_ready, 1);
      chk("wr_c3_paddr_hold", paddr, 8'h12);

      // Back-to-back with cmd_valid held
      tick();
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 8'h01;
      cmd_wdata = 8'h5E;
      exp_q.push_back('{rdata: 8'h00, err: 1'b0});
      exp_q.push_back('{rdata: 8'h5A, err: 1'b0});
      mid();
      tick();
      cmd_write = 1'b0;
      cmd_addr  = 8'h02;
      cmd_wdata = 8'h00;
      mid();
      chk("b2b_c1_ready", cmd_ready, 0);
      chk("b2b_c1_psel", psel, 1);
      chk("b2b_c1_paddr", paddr, 8'h01);
      chk("b2b_c1_pwrite", pwrite, 1);
      tick();
      mid();
      chk("b2b_c2_ready", cmd_ready, 0);
      chk("b2b_c2_pen", pen, 1);
      chk("b2b_c2_paddr", paddr, 8'h01);
      tick();
      prdata = 8'h5A;
      mid();
      chk("b2b_c3_psel", psel, 0);
      chk("b2b_c3_ready", cmd_ready, 1);
      chk("b2b_c3_rv", rsp_valid, 1);
      tick();
      cmd_valid = 1'b0;
      mid();
      chk("b2b_c4_psel", psel, 1);
      chk("b2b_c4_pen", pen, 0);
      chk("b2b_c4_paddr", paddr, 8'h02);
      chk("b2b_c4_pwrite", pwrite, 0);
      tick();
      mid();
      chk("b2b_c5_pen", pen, 1);
      tick();
      pready = 1'b0;
      mid();
      chk("b2b_c6_rv", rsp_valid, 1);
      chk("b2b_c6_rdata", rsp_rdata, 8'h5A);

`ifdef APB_MASTER_TIMEOUT_EN
      // Timeout abort after 4 ACCESS cycles
      tick();
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 8'h77;
      exp_q.push_back('{rdata: 8'h00, err: 1'b1});
      mid();
      tick();
      cmd_valid = 1'b0;
      mid();
      chk("to_c1_psel", psel, 1);
      for (int c = 2; c <= 5; c++) begin
         tick();
         mid();
         chk("to_access_pen", pen, 1);
         chk("to_access_rv", rsp_valid, 0);
      end
      tick();
      mid();
      chk("to_c6_rv", rsp_valid, 1);
      chk("to_c6_err", rsp_err, 1);
      chk("to_c6_rdata", rsp_rdata, 8'h00);
      chk("to_c6_pen", pen, 0);
      chk("to_c6_psel", psel, 0);
      // Park a transfer in ACCESS for the reset check
      tick();
      cmd_valid = 1'b1;
      cmd_addr  = 8'h33;
      mid();
      tick();
      cmd_valid = 1'b0;
      mid();
      tick();
      mid();
      chk("pre_rst_pen", pen, 1);
`else
      // No timeout: ACCESS waits indefinitely
      tick();
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 8'h77;
      mid();
      tick();
      cmd_valid = 1'b0;
      mid();
      for (int c = 0; c < 100; c++) begin
         tick();
         mid();
         chk("stuck_pen", pen, 1);
         chk("stuck_rv", rsp_valid, 0);
      end
`endif

      // Reset in the middle of ACCESS
      tick();
      #2 prst = 1'b0;
      #1;
      chk("mid_rst_psel", psel, 0);
      chk("mid_rst_pen", pen, 0);
      mid();
      chk("mid_rst_rv", rsp_valid, 0);
      tick();
      prst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         mid();
         chk("post_rst_ready", cmd_ready, 1);
         chk("post_rst_rv", rsp_valid, 0);
         chk("post_rst_psel", psel, 0);
      end
      chk("sb_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
